// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
package fifo_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: the first set request after ptr, searched modulo NUM_REQ
// over a doubled request vector so that the wrap needs no special case.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] pick,
  output logic                       any_req
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;

  assign dbl     = {req, req};
  assign any_req = |req;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  // The loop walks from the farthest to the nearest candidate, so the nearest set bit is the last one written.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (dbl[int'(ptr) + k]) pick = IDW'((int'(ptr) + k) % NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ requesters with packet-granular
// round-robin arbitration; an owner holds the port until its last beat is written.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATASIZE = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATASIZE-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [DATASIZE-1:0]          fifo_data,
  output logic [IDW-1:0]               grant_id,
  output logic                         busy
);

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick;
  logic           any_req;
  logic           xfer;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  // fifo_full reaches the state only through xfer, so a full FIFO simply freezes the owner.
  assign xfer       = (state == ARB_LOCK) & req_valid[grant_id] & ~fifo_full;
  assign fifo_wr_en = xfer;
  assign fifo_data  = req_data[int'(grant_id)*DATASIZE +: DATASIZE];

  always_comb begin
    req_ready = '0;
    if (state == ARB_LOCK) req_ready[grant_id] = ~fifo_full;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      grant_id <= '0;
      busy     <= 1'b0;
      ptr      <= IDW'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            busy     <= 1'b1;
            state    <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (xfer && req_last[grant_id]) begin
            state <= ARB_IDLE;
            ptr   <= grant_id;
            busy  <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester beat queues feed the DUT,
// a scoreboard of expected FIFO writes is checked by a forked monitor.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATASIZE = 4;

  logic                        clk;
  logic                        rst;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*DATASIZE-1:0] req_data;
  logic [NUM_REQ-1:0]          req_last;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        fifo_full;
  logic                        fifo_wr_en;
  logic [DATASIZE-1:0]         fifo_data;
  logic [1:0]                  grant_id;
  logic                        busy;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATASIZE(DATASIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Requester beat queues: {last, data}
  logic [DATASIZE:0] bmem [NUM_REQ][16];
  int                bhd  [NUM_REQ];
  int                btl  [NUM_REQ];
  logic [NUM_REQ-1:0] hold;
  logic [NUM_REQ-1:0] acc;

  // Scoreboard of expected FIFO writes
  logic [1:0]          exp_id   [64];
  logic [DATASIZE-1:0] exp_data [64];
  int                  exp_wr;
  int                  exp_rd;

  int pass_cnt;
  int total_cnt;

  logic               s_wr, s_busy;
  logic [1:0]         s_gid;
  logic [NUM_REQ-1:0] s_ready;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic beat(input int r, input logic [DATASIZE-1:0] d, input logic last);
    bmem[r][btl[r]] = {last, d};
    btl[r]++;
  endtask

  task automatic expect_wr(input logic [1:0] id, input logic [DATASIZE-1:0] d);
    exp_id[exp_wr]   = id;
    exp_data[exp_wr] = d;
    exp_wr++;
  endtask

  task automatic present();
    logic [DATASIZE:0] head;
    for (int i = 0; i < NUM_REQ; i++) begin
      head = (bhd[i] != btl[i]) ? bmem[i][bhd[i]] : '0;
      req_valid[i]                     = (bhd[i] != btl[i]) && !hold[i];
      req_last[i]                      = head[DATASIZE];
      req_data[i*DATASIZE +: DATASIZE] = head[DATASIZE-1:0];
    end
  endtask

  // One clock: snapshot outputs at negedge, then retire accepted beats after the edge.
  task automatic step();
    @(negedge clk);
    acc     = req_valid & req_ready;
    s_wr    = fifo_wr_en;
    s_busy  = busy;
    s_gid   = grant_id;
    s_ready = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) bhd[i]++;
    present();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_wr    = 0;
    exp_rd    = 0;
    hold      = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bhd[i] = 0;
      btl[i] = 0;
    end
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst && fifo_wr_en) begin
          if (exp_rd >= exp_wr) begin
            total_cnt++;
            $display("FAIL unexpected_write: owner %0d data %0h, no write expected", grant_id, fifo_data);
          end else begin
            check("wr_data", int'(fifo_data), int'(exp_data[exp_rd]));
            check("wr_owner", int'(grant_id), int'(exp_id[exp_rd]));
            exp_rd++;
          end
        end
      end
    join_none

    // Test 1/3: reset with every requester valid, then one single-beat packet each
    beat(0, 4'h1, 1'b1); beat(1, 4'h2, 1'b1); beat(2, 4'h3, 1'b1); beat(3, 4'h4, 1'b1);
    beat(0, 4'h5, 1'b1);
    present();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_grant", int'(grant_id), 0);
    check("rst_wr_en", int'(fifo_wr_en), 0);
    check("rst_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_wr(2'd0, 4'h1); expect_wr(2'd1, 4'h2); expect_wr(2'd2, 4'h3);
    expect_wr(2'd3, 4'h4); expect_wr(2'd0, 4'h5);
    for (int k = 0; k < 10; k++) begin
      step();
      check("rr_wr_pattern", int'(s_wr), k % 2);
      check("rr_busy_pattern", int'(s_busy), k % 2);
    end

    // Test 2: 3-beat packet from req0, FIFO never full
    beat(0, 4'h6, 1'b0); beat(0, 4'h7, 1'b0); beat(0, 4'h8, 1'b1);
    expect_wr(2'd0, 4'h6); expect_wr(2'd0, 4'h7); expect_wr(2'd0, 4'h8);
    present();
    for (int k = 0; k < 5; k++) begin
      step();
      check("pkt3_wr", int'(s_wr), (k >= 1 && k <= 3) ? 1 : 0);
      check("pkt3_busy", int'(s_busy), (k >= 1 && k <= 3) ? 1 : 0);
    end

    // Test 4: req2 4-beat packet with the FIFO full for 4 cycles after beat 1
    beat(2, 4'h9, 1'b0); beat(2, 4'hA, 1'b0); beat(2, 4'hB, 1'b0); beat(2, 4'hC, 1'b1);
    expect_wr(2'd2, 4'h9); expect_wr(2'd2, 4'hA); expect_wr(2'd2, 4'hB); expect_wr(2'd2, 4'hC);
    present();
    step();
    check("full_idle_wr", int'(s_wr), 0);
    step();
    check("full_first_wr", int'(s_wr), 1);
    check("full_first_ready", int'(s_ready), 4);
    fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("full_stall_wr", int'(s_wr), 0);
      check("full_stall_ready", int'(s_ready), 0);
      check("full_stall_grant", int'(s_gid), 2);
      check("full_stall_busy", int'(s_busy), 1);
    end
    fifo_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("full_resume_wr", int'(s_wr), 1);
    end
    step();
    check("full_done_busy", int'(s_busy), 0);

    // Test 5: req1 owns the port, drops valid mid-packet; req3 and req0 wait
    beat(1, 4'hD, 1'b0); beat(1, 4'hE, 1'b0); beat(1, 4'hF, 1'b1);
    expect_wr(2'd1, 4'hD); expect_wr(2'd1, 4'hE); expect_wr(2'd1, 4'hF);
    expect_wr(2'd3, 4'h0); expect_wr(2'd0, 4'h1);
    present();
    step();
    step();
    check("lock_first_wr", int'(s_wr), 1);
    beat(3, 4'h0, 1'b1);
    beat(0, 4'h1, 1'b1);
    hold[1] = 1'b1;
    present();
    for (int k = 0; k < 2; k++) begin
      step();
      check("drop_wr", int'(s_wr), 0);
      check("drop_grant", int'(s_gid), 1);
      check("drop_ready", int'(s_ready), 2);
    end
    hold[1] = 1'b0;
    present();
    for (int k = 0; k < 2; k++) begin
      step();
      check("resume_wr", int'(s_wr), 1);
      check("resume_ready", int'(s_ready), 2);
    end
    step();
    check("gap_wr", int'(s_wr), 0);
    step();
    check("next_grant", int'(s_gid), 3);
    step();
    step();
    check("after_grant", int'(s_gid), 0);
    step();

    // Test 6: reset after beat 2 of a 4-beat packet from req1
    beat(1, 4'h2, 1'b0); beat(1, 4'h3, 1'b0); beat(1, 4'h4, 1'b0); beat(1, 4'h5, 1'b1);
    expect_wr(2'd1, 4'h2); expect_wr(2'd1, 4'h3);
    present();
    step();
    step();
    step();
    check("mid_beat2_wr", int'(s_wr), 1);
    rst = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_wr_en", int'(fifo_wr_en), 0);
    check("midrst_ready", int'(req_ready), 0);
    check("midrst_grant", int'(grant_id), 0);
    bhd[1] = btl[1];
    present();
    step();
    rst = 1'b1;
    beat(0, 4'h6, 1'b1);
    beat(2, 4'h7, 1'b1);
    expect_wr(2'd0, 4'h6); expect_wr(2'd2, 4'h7);
    present();
    step();
    step();
    check("postrst_first_grant", int'(s_gid), 0);
    step();
    step();
    check("postrst_second_grant", int'(s_gid), 2);
    step();

    check("all_writes_seen", exp_rd, exp_wr);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
